rs_sched: RTL and testbench
===========================

Name: rs_sched

Overview:
- Small reservation station, one per execution port.
- Takes allocated uops from rename/RF read, each carrying two sources that are either already in the GRF or pending on a ROB writeback.
- Tracks source readiness by snooping the ROB writeback bus, capturing values as they arrive.
- Issues the oldest fully-ready entry to the downstream execution unit over a valid/ready handshake.

Parameters:
- NUM_ENTRIES, 4, number of RS entries (power of 2, 2..16).
- XLEN, 64, source data width.
- ROBID_W, 5, ROB id width.
- UOP_W, 32, opaque uop payload width carried to execute.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  kill all entries (pipeline flush)
- alloc_valid_rs0  in  1  allocation request
- alloc_ready_rs0  out  1  RS has a free entry
- alloc_uop_rs0  in  UOP_W  uop payload
- alloc_robid_rs0  in  ROBID_W  destination ROB id of the uop
- alloc_src_rs0[2]  in  2x(1+ROBID_W+XLEN)  per source: from_rob, robid, grf_data
- ro_valid_rb0  in  1  ROB writeback valid
- ro_result_rb0  in  ROBID_W+XLEN  writeback robid, value
- iss_valid_rs1  out  1  issue candidate valid
- iss_ready_rs1  in  1  execution unit accepts
- iss_uop_rs1  out  UOP_W  issued payload
- iss_robid_rs1  out  ROBID_W  issued destination ROB id
- iss_src_data_rs1[2]  out  2xXLEN  issued source operands

Behaviour:
- Reset: the clock is clk and the reset is reset_n, asynchronous and active-low. While reset_n is low:
  - all entries FREE;
  - iss_valid_rs1=0 and alloc_ready_rs0=1;
  - iss_* data outputs 0;
  - age matrix cleared.
- Entry FSM per entry: FREE -> WAIT (alloc with any source pending) or READY (alloc with both sources ready); WAIT -> READY when the last pending source is woken; READY -> FREE on issue handshake. flush forces FREE from any state.
- Allocation:
  - Accepted when alloc_valid_rs0 & alloc_ready_rs0.
  - Target is the lowest-index FREE entry.
  - alloc_ready_rs0 = any entry FREE; it is computed from registered state only, so an entry freed this cycle is not reused until next cycle.
- Source capture:
  - from_rob=0: grf_data is captured and the source is marked ready.
  - from_rob=1: source is marked pending on its robid.
  - Alloc-cycle wakeup: if ro_valid_rb0 matches a pending source's robid in the alloc cycle, the value is captured and the source is marked ready at allocation (no missed wakeup).
- Wakeup:
  - ro_valid_rb0 & robid match on a pending source of a WAIT entry captures the value; the source is ready next cycle.
  - One writeback may wake any number of sources or entries simultaneously.
  - Writebacks to FREE entries or already-ready sources are ignored.
- Age:
  - NUM_ENTRIES x NUM_ENTRIES age matrix, where older[i][j]=1 means entry i was allocated before entry j.
  - Row and column are set on alloc.
- Select:
  - iss_valid_rs1 = any READY entry.
  - The oldest READY entry drives iss_* combinationally from entry flops.
- Handshake:
  - Once iss_valid_rs1=1 and iss_ready_rs1=0, the selected entry is locked; payload and data must stay stable until accepted, even if an older entry becomes ready.
  - On iss_valid_rs1 & iss_ready_rs1, the entry goes FREE next cycle and the lock clears.
  - Max throughput is one issue per cycle.
- Latency:
  - Alloc with ready sources at t -> issue eligible at t+1.
  - Wakeup at t -> eligible at t+1.
- Simultaneous events:
  - flush has priority over alloc, wakeup and issue. A flush-cycle handshake is still considered accepted by execute, but no entry state survives.
  - Alloc and issue of different entries in the same cycle are independent.
- Full: alloc_ready_rs0=0. alloc_valid_rs0 held high must not corrupt state.

Optional Feature:
- RS_WAKEUP_BYPASS_EN defined:
  - An entry whose last pending source matches ro_result_rb0 in cycle t is select-eligible in cycle t.
  - Its iss_src_data_rs1 comes from ro_result_rb0.value, giving zero-cycle wakeup-to-issue.
  - Does not apply while the select lock is held.
- Undefined: wakeup-to-issue is exactly one cycle, and iss_* come only from flops.

Decomposition:
- Package rs_defs, shared with the rest of the RS:
  - t_rs_src_alloc: from_rob, robid, data.
  - t_rs_alloc: uop, robid, src[2].
  - t_rs_entry_state enum: FREE, WAIT, READY.
  - t_rob_result is reused from the ROB package.
- Sub-module rs_sched_entry holds one entry: FSM, two source slots with capture and match logic, and payload flops.
- rs_sched owns the free-list priority encoder, age matrix, select/lock and issue mux.

Test Plan:
- Alloc uop robid=3 with both srcs from GRF (0x11, 0x22) at t -> iss_valid_rs1=1 at t+1 with data 0x11/0x22; with iss_ready_rs1=1, entry FREE at t+2.
- Alloc src0 from_rob robid=7 -> no issue; writeback robid=7 value 0xDEAD at t -> issue at t+1 (t with RS_WAKEUP_BYPASS_EN) with src0=0xDEAD.
- Writeback robid=5 in the same cycle as an alloc with src1 pending on robid 5 -> entry READY immediately, issues the next cycle with the written value.
- Fill all 4 entries pending; alloc_ready_rs0=0 while alloc_valid_rs0 is held; wake entries 2 then 0 -> issue order 2 then 0. Wake 0 and 2 together -> the older one issues first.
- iss_ready_rs1=0 for 3 cycles while an older entry becomes ready -> iss_* stay unchanged until accepted.
- flush with 3 entries valid plus a same-cycle alloc -> all FREE next cycle, iss_valid_rs1=0, alloc_ready_rs0=1; async reset_n low mid-wakeup -> outputs at reset values immediately.

Source files
------------

// File: rtl/rs_sched_pkg.sv
// Shared reservation-station types: source/alloc packets, entry state and
// the ROB writeback result record.
package rs_defs;

    localparam int RS_XLEN    = 64;
    localparam int RS_ROBID_W = 5;
    localparam int RS_UOP_W   = 32;

    typedef struct packed {
        logic                  from_rob;
        logic [RS_ROBID_W-1:0] robid;
        logic [RS_XLEN-1:0]    data;
    } t_rs_src_alloc;

    typedef struct packed {
        logic [RS_UOP_W-1:0]     uop;
        logic [RS_ROBID_W-1:0]   robid;
        t_rs_src_alloc [1:0]     src;
    } t_rs_alloc;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } t_rs_entry_state;

    typedef struct packed {
        logic [RS_ROBID_W-1:0] robid;
        logic [RS_XLEN-1:0]    value;
    } t_rob_result;

endpackage

// File: rtl/rs_sched_entry.sv
// One reservation-station entry: state FSM, two source slots that snoop the
// ROB writeback bus, and the uop payload.
// Optional build macro RS_WAKEUP_BYPASS_EN: an entry whose last pending
// source is being written back this cycle is already select-eligible, with
// that operand forwarded straight from the writeback bus.
module rs_sched_entry
    import rs_defs::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush_i,
    input  logic                  alloc_en_i,
    input  t_rs_alloc             alloc_i,
    input  logic                  wb_valid_i,
    input  t_rob_result           wb_i,
    input  logic                  issue_ack_i,
    output logic                  free_o,
    output logic                  eligible_o,
    output logic [RS_UOP_W-1:0]   uop_o,
    output logic [RS_ROBID_W-1:0] robid_o,
    output logic [RS_XLEN-1:0]    src_data_o [2]
);

    t_rs_entry_state       state_q;
    logic [1:0]            rdy_q;
    logic [RS_ROBID_W-1:0] tag_q  [2];
    logic [RS_XLEN-1:0]    data_q [2];
    logic [RS_UOP_W-1:0]   uop_q;
    logic [RS_ROBID_W-1:0] robid_q;

    logic [1:0] match;
    logic [1:0] alloc_rdy;
    logic       alloc_take;
    logic       wake_all;

    // Tag match against the writeback bus, for both resident and incoming sources
    always_comb begin
        match      = '0;
        alloc_rdy  = '0;
        alloc_take = alloc_en_i && (state_q == FREE);
        for (int s = 0; s < 2; s++) begin
            match[s]     = wb_valid_i && (state_q == WAIT) && !rdy_q[s] &&
                           (wb_i.robid == tag_q[s]);
            alloc_rdy[s] = !alloc_i.src[s].from_rob ||
                           (wb_valid_i && (wb_i.robid == alloc_i.src[s].robid));
        end
        wake_all = (state_q == WAIT) && (&(rdy_q | match));
    end

    // Entry FSM and per-source ready bits; flush overrides everything
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FREE;
            rdy_q   <= '0;
        end else if (flush_i) begin
            state_q <= FREE;
            rdy_q   <= '0;
        end else begin
            case (state_q)
                FREE: begin
                    if (alloc_take) begin
                        rdy_q   <= alloc_rdy;
                        state_q <= (&alloc_rdy) ? READY : WAIT;
                    end
                end
                WAIT: begin
                    // An ack in WAIT only happens when a bypassed wakeup issued
                    if (issue_ack_i) begin
                        state_q <= FREE;
                    end else begin
                        rdy_q <= rdy_q | match;
                        if (wake_all) state_q <= READY;
                    end
                end
                READY: begin
                    if (issue_ack_i) state_q <= FREE;
                end
                default: state_q <= FREE;
            endcase
        end
    end

    // Payload and operand capture; data flops carry no reset
    always_ff @(posedge clk) begin
        if (alloc_take) begin
            uop_q   <= alloc_i.uop;
            robid_q <= alloc_i.robid;
            for (int s = 0; s < 2; s++) begin
                tag_q[s]  <= alloc_i.src[s].robid;
                data_q[s] <= alloc_i.src[s].from_rob ? wb_i.value : alloc_i.src[s].data;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (match[s]) data_q[s] <= wb_i.value;
            end
        end
    end

    assign free_o  = (state_q == FREE);
    assign uop_o   = uop_q;
    assign robid_o = robid_q;

`ifdef RS_WAKEUP_BYPASS_EN
    assign eligible_o    = (state_q == READY) || wake_all;
    assign src_data_o[0] = match[0] ? wb_i.value : data_q[0];
    assign src_data_o[1] = match[1] ? wb_i.value : data_q[1];
`else
    assign eligible_o    = (state_q == READY);
    assign src_data_o[0] = data_q[0];
    assign src_data_o[1] = data_q[1];
`endif

endmodule

// File: rtl/rs_sched.sv
// Reservation station scheduler: free-list allocation, age matrix,
// oldest-ready select with a hold lock, and the issue mux.
// Optional build macro RS_WAKEUP_BYPASS_EN enables zero-cycle
// wakeup-to-issue inside the entries.
module rs_sched
    import rs_defs::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int XLEN        = RS_XLEN,
    parameter int ROBID_W     = RS_ROBID_W,
    parameter int UOP_W       = RS_UOP_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                alloc_valid_rs0,
    output logic                alloc_ready_rs0,
    input  logic [UOP_W-1:0]    alloc_uop_rs0,
    input  logic [ROBID_W-1:0]  alloc_robid_rs0,
    input  t_rs_src_alloc       alloc_src_rs0 [2],
    input  logic                ro_valid_rb0,
    input  t_rob_result         ro_result_rb0,
    output logic                iss_valid_rs1,
    input  logic                iss_ready_rs1,
    output logic [UOP_W-1:0]    iss_uop_rs1,
    output logic [ROBID_W-1:0]  iss_robid_rs1,
    output logic [XLEN-1:0]     iss_src_data_rs1 [2]
);

    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    logic [NUM_ENTRIES-1:0] free_vec;
    logic [NUM_ENTRIES-1:0] elig_vec;
    logic [NUM_ENTRIES-1:0] alloc_en;
    logic [NUM_ENTRIES-1:0] issue_ack;
    logic [NUM_ENTRIES-1:0] pick_oh;
    logic [NUM_ENTRIES-1:0] sel_oh;
    logic [NUM_ENTRIES-1:0] lock_oh_q;
    logic [NUM_ENTRIES-1:0] older_q [NUM_ENTRIES];
    logic                   lock_q;
    logic                   alloc_fire;
    logic                   iss_fire;
    logic                   found;
    logic [IDX_W-1:0]       alloc_idx;

    logic [UOP_W-1:0]   ent_uop   [NUM_ENTRIES];
    logic [ROBID_W-1:0] ent_robid [NUM_ENTRIES];
    logic [XLEN-1:0]    ent_data  [NUM_ENTRIES][2];

    t_rs_alloc alloc_pkt;

    assign alloc_pkt.uop    = alloc_uop_rs0;
    assign alloc_pkt.robid  = alloc_robid_rs0;
    assign alloc_pkt.src[0] = alloc_src_rs0[0];
    assign alloc_pkt.src[1] = alloc_src_rs0[1];

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_ent
        rs_sched_entry u_entry (
            .clk         (clk),
            .reset_n     (reset_n),
            .flush_i     (flush),
            .alloc_en_i  (alloc_en[i]),
            .alloc_i     (alloc_pkt),
            .wb_valid_i  (ro_valid_rb0),
            .wb_i        (ro_result_rb0),
            .issue_ack_i (issue_ack[i]),
            .free_o      (free_vec[i]),
            .eligible_o  (elig_vec[i]),
            .uop_o       (ent_uop[i]),
            .robid_o     (ent_robid[i]),
            .src_data_o  (ent_data[i])
        );
    end

    // Lowest-index free entry from registered state only
    always_comb begin
        alloc_idx = '0;
        found     = 1'b0;
        alloc_en  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (free_vec[i] && !found) begin
                alloc_idx = IDX_W'(i);
                found     = 1'b1;
            end
        end
        alloc_ready_rs0 = |free_vec;
        alloc_fire      = alloc_valid_rs0 && alloc_ready_rs0 && !flush;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            alloc_en[i] = alloc_fire && (alloc_idx == IDX_W'(i));
        end
    end

    // Oldest eligible entry: one that is older than every other eligible one
    always_comb begin
        pick_oh = elig_vec;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                if (i != j && elig_vec[j] && !older_q[i][j]) pick_oh[i] = 1'b0;
            end
        end
        sel_oh        = lock_q ? lock_oh_q : pick_oh;
        iss_valid_rs1 = lock_q || (|elig_vec);
        iss_fire      = iss_valid_rs1 && iss_ready_rs1;
        issue_ack     = iss_fire ? sel_oh : '0;
    end

    // One-hot AND-OR issue mux; zero when nothing is selected
    always_comb begin
        iss_uop_rs1         = '0;
        iss_robid_rs1       = '0;
        iss_src_data_rs1[0] = '0;
        iss_src_data_rs1[1] = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (sel_oh[i]) begin
                iss_uop_rs1         = iss_uop_rs1 | ent_uop[i];
                iss_robid_rs1       = iss_robid_rs1 | ent_robid[i];
                iss_src_data_rs1[0] = iss_src_data_rs1[0] | ent_data[i][0];
                iss_src_data_rs1[1] = iss_src_data_rs1[1] | ent_data[i][1];
            end
        end
    end

    // Hold the presented entry while execute back-pressures
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_q    <= 1'b0;
            lock_oh_q <= '0;
        end else if (flush || iss_fire) begin
            lock_q    <= 1'b0;
            lock_oh_q <= '0;
        end else if (iss_valid_rs1 && !lock_q) begin
            lock_q    <= 1'b1;
            lock_oh_q <= pick_oh;
        end
    end

    // Age matrix: a new entry is younger than everyone, so clear its row and set its column
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) older_q[i] <= '0;
        end else if (alloc_fire) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (IDX_W'(i) == alloc_idx) older_q[i] <= '0;
                else                        older_q[i][alloc_idx] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rs_sched.sv
// Directed testbench for rs_sched with hand-computed expectations.
module tb_rs_sched;
    import rs_defs::*;

    logic          clk;
    logic          reset_n;
    logic          flush;
    logic          alloc_valid;
    logic          alloc_ready;
    logic [31:0]   alloc_uop;
    logic [4:0]    alloc_robid;
    t_rs_src_alloc alloc_src [2];
    logic          ro_valid;
    t_rob_result   ro_result;
    logic          iss_valid;
    logic          iss_ready;
    logic [31:0]   iss_uop;
    logic [4:0]    iss_robid;
    logic [63:0]   iss_data [2];

    int n_vec;
    int n_miss;

    rs_sched dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .flush            (flush),
        .alloc_valid_rs0  (alloc_valid),
        .alloc_ready_rs0  (alloc_ready),
        .alloc_uop_rs0    (alloc_uop),
        .alloc_robid_rs0  (alloc_robid),
        .alloc_src_rs0    (alloc_src),
        .ro_valid_rb0     (ro_valid),
        .ro_result_rb0    (ro_result),
        .iss_valid_rs1    (iss_valid),
        .iss_ready_rs1    (iss_ready),
        .iss_uop_rs1      (iss_uop),
        .iss_robid_rs1    (iss_robid),
        .iss_src_data_rs1 (iss_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alloc(input logic [31:0] uop, input logic [4:0] rid,
                             input logic fr0, input logic [4:0] r0, input logic [63:0] d0,
                             input logic fr1, input logic [4:0] r1, input logic [63:0] d1);
        alloc_valid           = 1'b1;
        alloc_uop             = uop;
        alloc_robid           = rid;
        alloc_src[0].from_rob = fr0;
        alloc_src[0].robid    = r0;
        alloc_src[0].data     = d0;
        alloc_src[1].from_rob = fr1;
        alloc_src[1].robid    = r1;
        alloc_src[1].data     = d1;
    endtask

    task automatic set_wb(input logic [4:0] rid, input logic [63:0] val);
        ro_valid        = 1'b1;
        ro_result.robid = rid;
        ro_result.value = val;
    endtask

    task automatic check_issue(input string tag, input logic [31:0] uop,
                               input logic [63:0] d0, input logic [63:0] d1);
        check({tag, "_valid"}, 64'(iss_valid), 64'd1);
        check({tag, "_uop"},   64'(iss_uop),   64'(uop));
        check({tag, "_src0"},  iss_data[0],    d0);
        check({tag, "_src1"},  iss_data[1],    d1);
    endtask

    initial begin
        n_vec       = 0;
        n_miss      = 0;
        reset_n     = 1'b0;
        flush       = 1'b0;
        iss_ready   = 1'b0;
        ro_valid    = 1'b0;
        ro_result   = '0;
        alloc_valid = 1'b0;
        alloc_uop   = '0;
        alloc_robid = '0;
        alloc_src[0] = '0;
        alloc_src[1] = '0;
        #3;
        check("rst_iss_valid",   64'(iss_valid),   64'd0);
        check("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        check("rst_iss_uop",     64'(iss_uop),     64'd0);
        check("rst_iss_src0",    iss_data[0],      64'd0);
        step();
        step();
        reset_n = 1'b1;
        step();

        // Both sources from GRF: eligible one cycle after alloc
        set_alloc(32'hA1, 5'd3, 1'b0, 5'd0, 64'h11, 1'b0, 5'd0, 64'h22);
        #1;
        check("grf_same_cycle_valid", 64'(iss_valid), 64'd0);
        step();
        alloc_valid = 1'b0;
        check_issue("grf_issue", 32'hA1, 64'h11, 64'h22);
        check("grf_robid", 64'(iss_robid), 64'd3);
        iss_ready = 1'b1;
        step();
        iss_ready = 1'b0;
        check("grf_freed", 64'(iss_valid), 64'd0);

        // Source 0 pending on ROB id 7
        set_alloc(32'hB2, 5'd4, 1'b1, 5'd7, 64'h0, 1'b0, 5'd0, 64'h33);
        step();
        alloc_valid = 1'b0;
        check("pend_no_issue", 64'(iss_valid), 64'd0);
        set_wb(5'd7, 64'hDEAD);
        #1;
`ifdef RS_WAKEUP_BYPASS_EN
        check("wake_same_cycle", 64'(iss_valid), 64'd1);
        check("wake_bypass_src0", iss_data[0], 64'hDEAD);
`else
        check("wake_same_cycle", 64'(iss_valid), 64'd0);
`endif
        step();
        ro_valid = 1'b0;
        check_issue("wake_issue", 32'hB2, 64'hDEAD, 64'h33);
        iss_ready = 1'b1;
        step();
        iss_ready = 1'b0;
        check("wake_freed", 64'(iss_valid), 64'd0);

        // Writeback in the allocation cycle is not missed
        set_alloc(32'hC3, 5'd6, 1'b0, 5'd0, 64'h44, 1'b1, 5'd5, 64'h0);
        set_wb(5'd5, 64'hBEEF);
        step();
        alloc_valid = 1'b0;
        ro_valid    = 1'b0;
        check_issue("alloc_wake", 32'hC3, 64'h44, 64'hBEEF);
        iss_ready = 1'b1;
        step();
        iss_ready = 1'b0;

        // Fill all entries with pending sources
        set_alloc(32'hE0, 5'd20, 1'b1, 5'd10, 64'h0, 1'b0, 5'd0, 64'd0);
        step();
        set_alloc(32'hE1, 5'd21, 1'b1, 5'd11, 64'h0, 1'b0, 5'd0, 64'd1);
        step();
        set_alloc(32'hE2, 5'd22, 1'b1, 5'd12, 64'h0, 1'b0, 5'd0, 64'd2);
        step();
        set_alloc(32'hE3, 5'd23, 1'b1, 5'd14, 64'h0, 1'b0, 5'd0, 64'd3);
        step();
        // Ready-looking payload held on the bus while full must not be taken
        set_alloc(32'hFF, 5'd31, 1'b0, 5'd0, 64'hF0, 1'b0, 5'd0, 64'hF1);
        check("full_alloc_ready", 64'(alloc_ready), 64'd0);
        check("full_no_issue",    64'(iss_valid),   64'd0);
        step();
        step();
        check("full_hold_ready", 64'(alloc_ready), 64'd0);
        check("full_hold_issue", 64'(iss_valid),   64'd0);
        alloc_valid = 1'b0;

        set_wb(5'd12, 64'h1212);
        step();
        ro_valid = 1'b0;
        check_issue("order_e2", 32'hE2, 64'h1212, 64'd2);
        iss_ready = 1'b1;
        step();
        iss_ready = 1'b0;
        check("order_e2_gone", 64'(iss_valid), 64'd0);
        set_wb(5'd10, 64'h1010);
        step();
        ro_valid = 1'b0;
        check_issue("order_e0", 32'hE0, 64'h1010, 64'd0);
        iss_ready = 1'b1;
        step();
        iss_ready = 1'b0;

        // New entry lands in slot 0 but is younger than slot 3
        set_alloc(32'hD0, 5'd25, 1'b1, 5'd14, 64'h0, 1'b0, 5'd0, 64'h99);
        step();
        alloc_valid = 1'b0;
        check("age_pending", 64'(iss_valid), 64'd0);
        set_wb(5'd14, 64'h1414);
        step();
        ro_valid = 1'b0;
        check_issue("age_older_first", 32'hE3, 64'h1414, 64'd3);
        iss_ready = 1'b1;
        step();
        check_issue("age_younger_next", 32'hD0, 64'h1414, 64'h99);
        step();
        iss_ready = 1'b0;
        check("age_drained", 64'(iss_valid), 64'd0);

        // Lock: presented entry stays while an older one wakes up
        set_alloc(32'hF5, 5'd26, 1'b0, 5'd0, 64'h55, 1'b0, 5'd0, 64'h66);
        step();
        alloc_valid = 1'b0;
        check_issue("lock_c0", 32'hF5, 64'h55, 64'h66);
        set_wb(5'd11, 64'h1111);
        step();
        ro_valid = 1'b0;
        check_issue("lock_c1", 32'hF5, 64'h55, 64'h66);
        step();
        check_issue("lock_c2", 32'hF5, 64'h55, 64'h66);
        check("lock_c2_robid", 64'(iss_robid), 64'd26);
        iss_ready = 1'b1;
        step();
        check_issue("lock_release", 32'hE1, 64'h1111, 64'd1);
        step();
        iss_ready = 1'b0;
        check("lock_drained", 64'(iss_valid), 64'd0);

        // Flush with three live entries and a same-cycle alloc
        set_alloc(32'h61, 5'd1, 1'b1, 5'd1, 64'h0, 1'b0, 5'd0, 64'h0);
        step();
        set_alloc(32'h62, 5'd2, 1'b1, 5'd2, 64'h0, 1'b0, 5'd0, 64'h0);
        step();
        set_alloc(32'h63, 5'd3, 1'b1, 5'd3, 64'h0, 1'b0, 5'd0, 64'h0);
        step();
        set_alloc(32'h64, 5'd4, 1'b0, 5'd0, 64'hAB, 1'b0, 5'd0, 64'hCD);
        flush = 1'b1;
        step();
        flush       = 1'b0;
        alloc_valid = 1'b0;
        check("flush_alloc_ready", 64'(alloc_ready), 64'd1);
        check("flush_iss_valid",   64'(iss_valid),   64'd0);
        set_wb(5'd1, 64'h0101);
        step();
        ro_valid = 1'b0;
        check("flush_no_wake", 64'(iss_valid), 64'd0);

        // Asynchronous reset in the middle of a wakeup cycle
        set_alloc(32'h77, 5'd7, 1'b0, 5'd0, 64'h77, 1'b0, 5'd0, 64'h78);
        step();
        alloc_valid = 1'b0;
        check("pre_reset_valid", 64'(iss_valid), 64'd1);
        set_wb(5'd9, 64'h9999);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid",       64'(iss_valid),   64'd0);
        check("async_rst_alloc_ready", 64'(alloc_ready), 64'd1);
        check("async_rst_uop",         64'(iss_uop),     64'd0);
        check("async_rst_src1",        iss_data[1],      64'd0);
        ro_valid = 1'b0;
        step();
        reset_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
